// File: rtl/hazard_controller.sv
// hazard_controller: decode-side pipeline sequencer for stalls, bubbles, flushes,
// execute-stage freeze and bus_a/bus_b forwarding selects.
module hazard_controller #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_wr,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_wr,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_wr,
    input  logic             redirect,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             turn_off,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FLUSH = 2'b10} state_t;
    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall, flush, bubble, freeze, load_use, redir, flushing;
    logic [1:0]       sel_a, sel_b;

    assign sel_a = (mem_reg_wr && mem_rd == id_rs1 && id_rs1 != '0) ? 2'b01 :
                   (wb_reg_wr && wb_rd == id_rs1 && id_rs1 != '0) ? 2'b10 : 2'b00;
    assign sel_b = (mem_reg_wr && mem_rd == id_rs2 && id_rs2 != '0) ? 2'b01 :
                   (wb_reg_wr && wb_rd == id_rs2 && id_rs2 != '0) ? 2'b10 : 2'b00;
    assign load_use = id_valid && ex_is_load && ex_reg_wr && ex_rd != '0 &&
                      ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    // A parked redirect or parked flush cycles resume on the cycle memory releases.
    assign redir    = redirect || pend_q;
    assign flushing = state_q == FLUSH || (state_q == MEM_WAIT && cnt_q != '0);

    always_comb begin
        state_d = RUN;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        stall   = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        freeze  = 1'b0;
        if (mem_busy) begin
            stall   = 1'b1;
            freeze  = 1'b1;
            state_d = MEM_WAIT;
            pend_d  = pend_q || redirect;
        end else if (redir) begin
            flush   = 1'b1;
            pend_d  = 1'b0;
            cnt_d   = RELOAD;
            state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        end else if (flushing) begin
            flush   = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q > 3'd1 ? FLUSH : RUN;
        end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_pc  = clear & stall;
    assign stall_id  = clear & stall;
    assign flush_id  = clear & flush;
    assign bubble_ex = clear & bubble;
    assign turn_off  = clear & freeze;
    assign fwd_a     = clear ? sel_a : 2'b00;
    assign fwd_b     = clear ? sel_b : 2'b00;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors for hazard_controller with default,
// three-cycle-flush and 2-bit-counter instances sharing one stimulus.
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       clear;
    logic       id_valid, id_use_rs1, id_use_rs2, ex_reg_wr, ex_is_load;
    logic       mem_reg_wr, wb_reg_wr, redirect, mem_busy;
    logic [3:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       a_spc, a_sid, a_fid, a_bub, a_off, b_spc, b_sid, b_fid, b_bub, b_off;
    logic       c_spc, c_sid, c_fid, c_bub, c_off;
    logic [1:0] a_fa, a_fb, a_st, b_fa, b_fb, b_st, c_fa, c_fb, c_st;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_controller u_dut (
        .clk(clk), .clear(clear), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd),
        .wb_reg_wr(wb_reg_wr), .redirect(redirect), .mem_busy(mem_busy), .stall_pc(a_spc),
        .stall_id(a_sid), .flush_id(a_fid), .bubble_ex(a_bub), .turn_off(a_off),
        .fwd_a(a_fa), .fwd_b(a_fb), .state(a_st), .stall_cnt(a_cnt));

    hazard_controller #(.FLUSH_CYCLES(3)) u_f3 (
        .clk(clk), .clear(clear), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd),
        .wb_reg_wr(wb_reg_wr), .redirect(redirect), .mem_busy(mem_busy), .stall_pc(b_spc),
        .stall_id(b_sid), .flush_id(b_fid), .bubble_ex(b_bub), .turn_off(b_off),
        .fwd_a(b_fa), .fwd_b(b_fb), .state(b_st), .stall_cnt(b_cnt));

    hazard_controller #(.CNT_W(2)) u_sat (
        .clk(clk), .clear(clear), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd),
        .wb_reg_wr(wb_reg_wr), .redirect(redirect), .mem_busy(mem_busy), .stall_pc(c_spc),
        .stall_id(c_sid), .flush_id(c_fid), .bubble_ex(c_bub), .turn_off(c_off),
        .fwd_a(c_fa), .fwd_b(c_fb), .state(c_st), .stall_cnt(c_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        {id_valid, id_use_rs1, id_use_rs2, ex_reg_wr, ex_is_load} = '0;
        {mem_reg_wr, wb_reg_wr, redirect, mem_busy} = '0;
        {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
    endtask

    task automatic reset_pulse;
        clear = 1'b0;
        #1;
        @(negedge clk);
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0;
        idle();
        mem_rd = 4'd5; mem_reg_wr = 1'b1; id_rs1 = 4'd5; mem_busy = 1'b1;
        #2;
        chk("rst_state", a_st, 2'b00);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_fwd_a", a_fa, 2'b00);
        chk("rst_turn_off", a_off, 1'b0);
        chk("rst_stall_pc", a_spc, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        idle();
        // load r3 in EX, decode reads r3 as rs1
        ex_rd = 4'd3; ex_is_load = 1'b1; ex_reg_wr = 1'b1;
        id_valid = 1'b1; id_rs1 = 4'd3; id_use_rs1 = 1'b1; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
        #1;
        chk("lu_stall_pc", a_spc, 1'b1);
        chk("lu_stall_id", a_sid, 1'b1);
        chk("lu_bubble", a_bub, 1'b1);
        chk("lu_turn_off", a_off, 1'b0);
        chk("lu_fwd_a_pre", a_fa, 2'b00);
        tick();
        ex_rd = 4'd0; ex_is_load = 1'b0; ex_reg_wr = 1'b0; mem_rd = 4'd3; mem_reg_wr = 1'b1;
        #1;
        chk("lu_fwd_a", a_fa, 2'b01);
        chk("lu_release", a_spc, 1'b0);
        chk("lu_cnt", a_cnt, 1);
        tick();
        idle();
        mem_rd = 4'd5; mem_reg_wr = 1'b1; wb_rd = 4'd5; wb_reg_wr = 1'b1; id_rs2 = 4'd5;
        #1;
        chk("fwd_b_mem", a_fb, 2'b01);
        chk("fwd_a_r0", a_fa, 2'b00);
        mem_reg_wr = 1'b0;
        #1;
        chk("fwd_b_wb", a_fb, 2'b10);
        id_rs2 = 4'd0;
        #1;
        chk("fwd_b_none", a_fb, 2'b00);
        idle();
        // load to r0 never stalls or forwards
        ex_rd = 4'd0; ex_is_load = 1'b1; ex_reg_wr = 1'b1; id_valid = 1'b1;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
        #1;
        chk("r0_stall", a_spc, 1'b0);
        chk("r0_bubble", a_bub, 1'b0);
        chk("r0_fwd_a", a_fa, 2'b00);
        chk("r0_fwd_b", a_fb, 2'b00);
        tick();
        idle();
        reset_pulse();
        mem_busy = 1'b1;
        #1;
        chk("mw1_turn_off", a_off, 1'b1);
        chk("mw1_state", a_st, 2'b00);
        tick();
        redirect = 1'b1;
        #1;
        chk("mw2_turn_off", a_off, 1'b1);
        chk("mw2_state", a_st, 2'b01);
        chk("mw2_flush", a_fid, 1'b0);
        tick();
        redirect = 1'b0;
        for (int i = 3; i <= 4; i++) begin
            chk($sformatf("mw%0d_turn_off", i), a_off, 1'b1);
            tick();
        end
        mem_busy = 1'b0;
        #1;
        chk("mw_rel_flush", a_fid, 1'b1);
        chk("mw_rel_turn_off", a_off, 1'b0);
        chk("mw_rel_stall_pc", a_spc, 1'b0);
        chk("mw_rel_cnt", a_cnt, 4);
        chk("mw_sat_cnt", c_cnt, 3);
        tick();
        chk("mw_after_state", a_st, 2'b00);
        chk("mw_after_flush", a_fid, 1'b0);
        tick();
        tick();
        tick();
        chk("f3_idle_state", b_st, 2'b00);
        // redirect with a simultaneous load-use on the three-cycle-flush instance
        redirect = 1'b1;
        ex_rd = 4'd2; ex_is_load = 1'b1; ex_reg_wr = 1'b1; id_valid = 1'b1;
        id_rs1 = 4'd2; id_use_rs1 = 1'b1;
        #1;
        chk("f3_c0_flush", b_fid, 1'b1);
        chk("f3_c0_bubble", b_bub, 1'b0);
        chk("f3_c0_stall", b_spc, 1'b0);
        tick();
        idle();
        #1;
        chk("f3_c1_state", b_st, 2'b10);
        chk("f3_c1_flush", b_fid, 1'b1);
        tick();
        chk("f3_c2_state", b_st, 2'b10);
        chk("f3_c2_flush", b_fid, 1'b1);
        tick();
        chk("f3_c3_state", b_st, 2'b00);
        chk("f3_c3_flush", b_fid, 1'b0);
        // memory wait inside a flush keeps the remaining flush cycles
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        mem_busy = 1'b1;
        #1;
        chk("f3w_busy_flush", b_fid, 1'b0);
        chk("f3w_busy_off", b_off, 1'b1);
        tick();
        mem_busy = 1'b0;
        #1;
        chk("f3w_rel_state", b_st, 2'b01);
        chk("f3w_rel_flush", b_fid, 1'b1);
        tick();
        chk("f3w_resume_state", b_st, 2'b10);
        chk("f3w_resume_flush", b_fid, 1'b1);
        tick();
        chk("f3w_done_state", b_st, 2'b00);
        idle();
        // async reset while waiting on memory with a pending redirect
        mem_busy = 1'b1; redirect = 1'b1; mem_rd = 4'd5; mem_reg_wr = 1'b1; id_rs1 = 4'd5;
        tick();
        redirect = 1'b0;
        chk("ar_state_pre", a_st, 2'b01);
        tick();
        #2;
        clear = 1'b0;
        #1;
        chk("ar_state", a_st, 2'b00);
        chk("ar_turn_off", a_off, 1'b0);
        chk("ar_stall_pc", a_spc, 1'b0);
        chk("ar_cnt", a_cnt, 0);
        chk("ar_fwd_a", a_fa, 2'b00);
        @(negedge clk);
        clear = 1'b1;
        mem_busy = 1'b0;
        #1;
        chk("ar_rel_flush", a_fid, 1'b0);
        chk("ar_rel_fwd_a", a_fa, 2'b01);
        tick();
        chk("ar_next_flush", a_fid, 1'b0);
        chk("ar_next_state", a_st, 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
